// File: rtl/unidade_controle_jogo_pkg.sv
// Shared definitions for the memory-sequence game control unit:
// 5-bit state codes (also driven on db_estado) and LED mux selector values.
package unidade_controle_jogo_pkg;

    typedef enum logic [4:0] {
        INICIAL        = 5'h00,
        PREPARACAO     = 5'h01,
        MOSTRA         = 5'h02,
        APAGA          = 5'h03,
        PROXIMO_MOSTRA = 5'h04,
        INICIA_JOGADA  = 5'h05,
        ESPERA         = 5'h06,
        REGISTRA       = 5'h07,
        COMPARA        = 5'h08,
        PROXIMO        = 5'h09,
        NOVA_RODADA    = 5'h0A,
        FIM_ACERTO     = 5'h0B,
        FIM_ERRO       = 5'h0C,
        FIM_TIMEOUT    = 5'h0D
    } estado_t;

    localparam logic [1:0] SEL_APAGADO = 2'b00;
    localparam logic [1:0] SEL_MEMORIA = 2'b01;
    localparam logic [1:0] SEL_BOTOES  = 2'b10;

endpackage

// File: rtl/unidade_controle_jogo.sv
// Moore control unit for the memory-sequence game.
// Optional feature macro: JOGO_TIMEOUT_EN (move timeout; when undefined,
// contaT stays 0, the timeout input is ignored and fim_timeout decodes as
// an unused code).
// Handshake: jogada_feita is a one-cycle pulse from the datapath and is
// only acted on while the FSM sits in espera; there is no back-pressure,
// a pulse arriving in any other state is dropped.
// The current state is always visible on db_estado.
module unidade_controle_jogo
    import unidade_controle_jogo_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       fimM,
    input  logic       meioM,
    input  logic       fimL,
    input  logic       endecoIgualLimite,
    input  logic       botoesIgualMemoria,
    input  logic       jogada_feita,
    input  logic       timeout,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       zeraM,
    output logic       contaM,
    output logic       contaT,
    output logic [1:0] seletor,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic [4:0] db_estado
);

    estado_t estadoAtual;
    estado_t proximoEstado;

`ifndef JOGO_TIMEOUT_EN
    // Timeout input has no effect when the feature is compiled out.
    logic timeoutIgnorado;
    assign timeoutIgnorado = timeout;
`endif

    // State register: asynchronous return to inicial on reset low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estadoAtual <= INICIAL;
        else        estadoAtual <= proximoEstado;
    end

    // Next-state logic; unknown codes fall back to inicial.
    always_comb begin
        proximoEstado = estadoAtual;
        case (estadoAtual)
            INICIAL:        if (iniciar) proximoEstado = PREPARACAO;
            PREPARACAO:     proximoEstado = MOSTRA;
            MOSTRA:         if (meioM) proximoEstado = APAGA;
            APAGA:          if (fimM) proximoEstado = endecoIgualLimite ? INICIA_JOGADA : PROXIMO_MOSTRA;
            PROXIMO_MOSTRA: proximoEstado = MOSTRA;
            INICIA_JOGADA:  proximoEstado = ESPERA;
            ESPERA: begin
                // A move pulse wins over a simultaneous timeout.
                if (jogada_feita) proximoEstado = REGISTRA;
`ifdef JOGO_TIMEOUT_EN
                else if (timeout) proximoEstado = FIM_TIMEOUT;
`endif
            end
            REGISTRA:       proximoEstado = COMPARA;
            COMPARA: begin
                if (!botoesIgualMemoria)    proximoEstado = FIM_ERRO;
                else if (endecoIgualLimite) proximoEstado = fimL ? FIM_ACERTO : NOVA_RODADA;
                else                        proximoEstado = PROXIMO;
            end
            PROXIMO:        proximoEstado = ESPERA;
            NOVA_RODADA:    proximoEstado = MOSTRA;
            FIM_ACERTO,
`ifdef JOGO_TIMEOUT_EN
            FIM_TIMEOUT,
`endif
            FIM_ERRO:       if (iniciar) proximoEstado = PREPARACAO;
            default:        proximoEstado = INICIAL;
        endcase
    end

    // Output decode from the current state only.
    always_comb begin
        zeraE     = 1'b0;
        contaE    = 1'b0;
        zeraL     = 1'b0;
        contaL    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        zeraM     = 1'b0;
        contaM    = 1'b0;
        contaT    = 1'b0;
        seletor   = SEL_APAGADO;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        case (estadoAtual)
            PREPARACAO: begin
                zeraE = 1'b1;
                zeraL = 1'b1;
                zeraR = 1'b1;
                zeraM = 1'b1;
            end
            MOSTRA: begin
                seletor = SEL_MEMORIA;
                contaM  = 1'b1;
            end
            APAGA:          contaM = 1'b1;
            PROXIMO_MOSTRA: begin
                contaE = 1'b1;
                zeraM  = 1'b1;
            end
            INICIA_JOGADA: begin
                zeraE = 1'b1;
                zeraR = 1'b1;
            end
            ESPERA: begin
                // Dropping contaT elsewhere clears the timeout counter per move.
`ifdef JOGO_TIMEOUT_EN
                contaT  = 1'b1;
`endif
                seletor = SEL_BOTOES;
            end
            REGISTRA: begin
                registraR = 1'b1;
                seletor   = SEL_BOTOES;
            end
            COMPARA:        seletor = SEL_BOTOES;
            PROXIMO:        contaE = 1'b1;
            NOVA_RODADA: begin
                contaL = 1'b1;
                zeraE  = 1'b1;
                zeraM  = 1'b1;
            end
            FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
`ifdef JOGO_TIMEOUT_EN
            FIM_TIMEOUT,
`endif
            FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estadoAtual;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Self-checking bench for unidade_controle_jogo (honours JOGO_TIMEOUT_EN).
module tb_unidade_controle_jogo;
    import unidade_controle_jogo_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       fimM = 1'b0;
    logic       meioM = 1'b0;
    logic       fimL = 1'b0;
    logic       endecoIgualLimite = 1'b0;
    logic       botoesIgualMemoria = 1'b0;
    logic       jogada_feita = 1'b0;
    logic       timeout = 1'b0;
    logic       zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraM, contaM, contaT;
    logic [1:0] seletor;
    logic       pronto, acertou, errou;
    logic [4:0] db_estado;

    logic [18:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          contaLPulsos = 0;

    logic [13:0] obsSaidas;
    assign obsSaidas = {zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraM,
                        contaM, contaT, seletor, pronto, acertou, errou};

    unidade_controle_jogo dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .fimM(fimM), .meioM(meioM),
        .fimL(fimL), .endecoIgualLimite(endecoIgualLimite),
        .botoesIgualMemoria(botoesIgualMemoria), .jogada_feita(jogada_feita),
        .timeout(timeout), .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL),
        .contaL(contaL), .zeraR(zeraR), .registraR(registraR), .zeraM(zeraM),
        .contaM(contaM), .contaT(contaT), .seletor(seletor), .pronto(pronto),
        .acertou(acertou), .errou(errou), .db_estado(db_estado)
    );

    // Clock
    always #5 clock = ~clock;

    // Expected Moore outputs for a state code, straight from the state table.
    function automatic logic [13:0] saidasEsperadas(input logic [4:0] codigo);
        logic ze, ce, zl, cl, zr, rr, zm, cm, ct, pr, ac, er;
        logic [1:0] sel;
        {ze, ce, zl, cl, zr, rr, zm, cm, ct, pr, ac, er} = '0;
        sel = SEL_APAGADO;
        case (codigo)
            5'h01: begin ze = 1; zl = 1; zr = 1; zm = 1; end
            5'h02: begin sel = SEL_MEMORIA; cm = 1; end
            5'h03: cm = 1;
            5'h04: begin ce = 1; zm = 1; end
            5'h05: begin ze = 1; zr = 1; end
            5'h06: begin
`ifdef JOGO_TIMEOUT_EN
                ct = 1;
`endif
                sel = SEL_BOTOES;
            end
            5'h07: begin rr = 1; sel = SEL_BOTOES; end
            5'h08: sel = SEL_BOTOES;
            5'h09: ce = 1;
            5'h0A: begin cl = 1; ze = 1; zm = 1; end
            5'h0B: begin pr = 1; ac = 1; end
            5'h0C, 5'h0D: begin pr = 1; er = 1; end
            default: ;
        endcase
        return {ze, ce, zl, cl, zr, rr, zm, cm, ct, sel, pr, ac, er};
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        checks++;
        if (obs !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, expected, $time);
        end
    endtask

    // Driver: push expected result, advance one clock, then pop and compare.
    task automatic passo(input logic [4:0] estadoEsperado);
        logic [18:0] e;
        exp_q.push_back({estadoEsperado, saidasEsperadas(estadoEsperado)});
        @(posedge clock);
        #1;
        if (contaL) contaLPulsos++;
        e = exp_q.pop_front();
        checkValue("estado", 32'(db_estado), 32'(e[18:14]));
        checkValue("saidas", 32'(obsSaidas), 32'(e[13:0]));
    endtask

    task automatic limparEntradas();
        iniciar = 0; fimM = 0; meioM = 0; fimL = 0; endecoIgualLimite = 0;
        botoesIgualMemoria = 0; jogada_feita = 0; timeout = 0;
    endtask

    initial begin
        // Reset block
        #2 reset = 1'b0;
        #1;
        checkValue("reset_estado", 32'(db_estado), 32'h00);
        checkValue("reset_saidas", 32'(obsSaidas), 32'h0);
        #22 reset = 1'b1;
        passo(INICIAL);
        passo(INICIAL);

        // Start, then reset while in mostra
        iniciar = 1; passo(PREPARACAO); iniciar = 0;
        passo(MOSTRA);
        #3 reset = 1'b0;
        #1;
        checkValue("reset_meio_estado", 32'(db_estado), 32'h00);
        checkValue("reset_meio_saidas", 32'(obsSaidas), 32'h0);
        #3 reset = 1'b1;
        iniciar = 1; passo(PREPARACAO); iniciar = 0;
        passo(MOSTRA);

        // Round 0, correct move
        contaLPulsos = 0;
        passo(MOSTRA);
        meioM = 1; passo(APAGA); meioM = 0;
        passo(APAGA);
        fimM = 1; endecoIgualLimite = 1; passo(INICIA_JOGADA); limparEntradas();
        passo(ESPERA);
        jogada_feita = 1; passo(REGISTRA); jogada_feita = 0;
        passo(COMPARA);
        botoesIgualMemoria = 1; endecoIgualLimite = 1; passo(NOVA_RODADA); limparEntradas();
        passo(MOSTRA);
        checkValue("contaL_rodada0", 32'(contaLPulsos), 32'd1);

        // Round 1: two entries shown, first move right, second wrong
        meioM = 1; passo(APAGA); meioM = 0;
        fimM = 1; passo(PROXIMO_MOSTRA); fimM = 0;
        passo(MOSTRA);
        meioM = 1; passo(APAGA); meioM = 0;
        fimM = 1; endecoIgualLimite = 1; passo(INICIA_JOGADA); limparEntradas();
        passo(ESPERA);
        jogada_feita = 1; passo(REGISTRA); jogada_feita = 0;
        passo(COMPARA);
        botoesIgualMemoria = 1; passo(PROXIMO); limparEntradas();
        passo(ESPERA);
        jogada_feita = 1; timeout = 1; passo(REGISTRA); limparEntradas();
        passo(COMPARA);
        botoesIgualMemoria = 0; endecoIgualLimite = 1; passo(FIM_ERRO); limparEntradas();
        passo(FIM_ERRO);
        passo(FIM_ERRO);
        iniciar = 1; passo(PREPARACAO); iniciar = 0;

        // Timeout while waiting for a move
        passo(MOSTRA);
        meioM = 1; passo(APAGA); meioM = 0;
        fimM = 1; endecoIgualLimite = 1; passo(INICIA_JOGADA); limparEntradas();
        passo(ESPERA);
        repeat ($urandom_range(20, 60)) passo(ESPERA);
        timeout = 1;
`ifdef JOGO_TIMEOUT_EN
        passo(FIM_TIMEOUT);
        passo(FIM_TIMEOUT);
        timeout = 0;
        passo(FIM_TIMEOUT);
`else
        passo(ESPERA);
        passo(ESPERA);
        timeout = 0;
        jogada_feita = 1; passo(REGISTRA); jogada_feita = 0;
        passo(COMPARA);
        passo(FIM_ERRO);
`endif
        iniciar = 1; passo(PREPARACAO); iniciar = 0;

        // Full game: 16 rounds, all moves correct
        contaLPulsos = 0;
        passo(MOSTRA);
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i <= r; i++) begin
                repeat ($urandom_range(0, 2)) passo(MOSTRA);
                meioM = 1; passo(APAGA); meioM = 0;
                repeat ($urandom_range(0, 2)) passo(APAGA);
                fimM = 1; endecoIgualLimite = (i == r);
                if (i == r) passo(INICIA_JOGADA);
                else        passo(PROXIMO_MOSTRA);
                limparEntradas();
                if (i != r) passo(MOSTRA);
            end
            passo(ESPERA);
            for (int i = 0; i <= r; i++) begin
                repeat ($urandom_range(0, 3)) passo(ESPERA);
                jogada_feita = 1; passo(REGISTRA); jogada_feita = 0;
                passo(COMPARA);
                botoesIgualMemoria = 1; endecoIgualLimite = (i == r); fimL = (r == 15);
                if (i < r)        passo(PROXIMO);
                else if (r == 15) passo(FIM_ACERTO);
                else              passo(NOVA_RODADA);
                limparEntradas();
                if (i < r)        passo(ESPERA);
                else if (r < 15)  passo(MOSTRA);
            end
        end
        passo(FIM_ACERTO);
        passo(FIM_ACERTO);
        checkValue("contaL_jogo", 32'(contaLPulsos), 32'd15);

        // Report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/unidade_controle_jogo.md
Name: unidade_controle_jogo

Overview:
- Moore control unit for the memory-sequence game; sits directly downstream of the datapath and consumes its status flags.
- Drives every datapath control strobe and the LED mux selector.
- Sequence per round: show ROM entries 0..limit on the LEDs, collect player moves, compare, then grow the limit or end the game.
- Exposes game-result and debug outputs to the top level.

Parameters:
- none (timing comes from the datapath counters: display counter M=1000, timeout counter M=4000)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- iniciar  in  1  start request, level-sampled
- fimM  in  1  display counter at terminal count
- meioM  in  1  display counter at half count
- fimL  in  1  limit counter at 15
- endecoIgualLimite  in  1  address == limit
- botoesIgualMemoria  in  1  registered move == ROM data
- jogada_feita  in  1  one-cycle move pulse
- timeout  in  1  timeout counter expired
- zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraM, contaM, contaT  out  1 each  datapath strobes
- seletor  out  2  LED mux select: 00 off, 01 ROM, 10 buttons
- pronto  out  1  game finished
- acertou  out  1  game won
- errou  out  1  wrong move or timeout
- db_estado  out  5  current state code

Behaviour:
- State register: async clear to inicial on reset low; all other updates on the rising edge of clock.
- All outputs are decoded from state only (Moore). Any output not listed for a state is 0; seletor defaults to 00.
- Reset mid-game: immediate return to inicial; all outputs 0 in the same cycle.
- State codes: inicial 00, preparacao 01, mostra 02, apaga 03, proximo_mostra 04, inicia_jogada 05, espera 06, registra 07, compara 08, proximo 09, nova_rodada 0A, fim_acerto 0B, fim_erro 0C, fim_timeout 0D. Any unused code → inicial.
- inicial: iniciar=1 → preparacao.
- preparacao: zeraE, zeraL, zeraR, zeraM → mostra.
- mostra: seletor=01, contaM; meioM=1 → apaga.
- apaga: seletor=00, contaM; on fimM:
  - endecoIgualLimite=1 → inicia_jogada
  - else → proximo_mostra
- proximo_mostra: contaE, zeraM → mostra.
- inicia_jogada: zeraE, zeraR → espera.
- espera: contaT, seletor=10. Priority order:
  - jogada_feita → registra
  - else timeout → fim_timeout
  - Simultaneous jogada_feita and timeout: the move wins.
- registra: registraR, seletor=10 → compara.
- compara: seletor=10.
  - botoesIgualMemoria=0 → fim_erro
  - else endecoIgualLimite=1 → (fimL ? fim_acerto : nova_rodada)
  - else → proximo
- proximo: contaE → espera.
- nova_rodada: contaL, zeraE, zeraM → mostra (next round shows one more entry).
- fim_acerto: pronto=1, acertou=1.
- fim_erro / fim_timeout: pronto=1, errou=1.
- All three terminal states: iniciar=1 → preparacao; otherwise hold.
- Latency: move pulse to result decision is 2 cycles (espera→registra→compara).
- contaT is deasserted outside espera, which clears the timeout counter, so each move gets the full 4000 cycles.

Optional Feature:
- Macro: JOGO_TIMEOUT_EN.
- Defined: behaviour as above.
- Undefined: contaT is forced to 0, the timeout input is ignored, and fim_timeout is unreachable (its code decodes as unused → inicial).

Decomposition:
- Shared package holds:
  - 5-bit state code constants
  - seletor constants SEL_APAGADO=2'b00, SEL_MEMORIA=2'b01, SEL_BOTOES=2'b10
- No sub-module. Single file: next-state block, state register, output decode.

Test Plan:
- Reset low mid-mostra → db_estado=00 and all outputs 0 immediately; iniciar=1 after release → db_estado goes 01 then 02.
- Round 0, ROM[0] applied correctly → path 02,03,05,06,07,08,0A, then 02; contaL pulses once.
- Wrong move in espera with botoesIgualMemoria=0 → 0C; pronto=1, errou=1, acertou=0; holds until iniciar.
- With JOGO_TIMEOUT_EN defined, no move for 4000 cycles → 0D, errou=1. Without the macro → stays 06 and contaT=0.
- Full game: 16 rounds, all correct, fimL=1 at the last compare → 0B, acertou=1; contaL pulsed 15 times.
- jogada_feita and timeout asserted in the same cycle while in espera → next state 07, not 0D.
